// File: rtl/ahb2apb_bridge_pready.sv
// AHB-to-APB3 bridge: one AHB transfer in flight, APB wait states via Pready,
// slave/decode/timeout errors returned as a two-cycle AHB ERROR response.
module ahb2apb_bridge_pready #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                SLV_SHIFT   = 26,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [DATA_W-1:0]  Prdata,
  input  logic               Pready,
  input  logic               Pslverr,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [NUM_SLV-1:0] Psel,
  output logic               Penable,
  output logic               Pwrite,
  output logic [ADDR_W-1:0]  Paddr,
  output logic [DATA_W-1:0]  Pwdata
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam int         CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t            state_r;
  logic [3:0]        idx_r;
  logic [CNT_W-1:0]  tout_cnt_r;

  logic [ADDR_W-1:0] slot_s;
  logic [3:0]        idx_s;
  logic              decode_ok_s;
  logic              capture_s;
  logic              unused_htrans_s;

  assign unused_htrans_s = Htrans[0];

  function automatic logic [NUM_SLV-1:0] onehot(input logic [3:0] idx);
    logic [NUM_SLV-1:0] res;
    for (int i = 0; i < NUM_SLV; i++) begin
      res[i] = (idx == 4'(i));
    end
    return res;
  endfunction

  // Address decode and capture qualification for the current AHB address phase
  always_comb begin
    slot_s      = (Haddr - BASE_ADDR) >> SLV_SHIFT;
    idx_s       = slot_s[3:0];
    decode_ok_s = (Haddr >= BASE_ADDR) && (slot_s < ADDR_W'(NUM_SLV));
    capture_s   = Hreadyout && Hreadyin && Htrans[1] &&
                  ((state_r == ST_IDLE) || (state_r == ST_ERR2));
  end

  // Bridge FSM with all bus-facing outputs registered
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      tout_cnt_r <= '0;
      Hreadyout  <= 1'b1;
      Hresp      <= RESP_OKAY;
      Hrdata     <= '0;
      Psel       <= '0;
      Penable    <= 1'b0;
      Pwrite     <= 1'b0;
      Paddr      <= '0;
      Pwdata     <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ERR2: begin
          if (capture_s) begin
            Hreadyout <= 1'b0;
            if (!decode_ok_s) begin
              state_r <= ST_ERR1;
              Hresp   <= RESP_ERROR;
            end else begin
              Hresp  <= RESP_OKAY;
              idx_r  <= idx_s;
              Paddr  <= Haddr;
              Pwrite <= Hwrite;
              if (Hwrite) begin
                state_r <= ST_WLATCH;
              end else begin
                state_r <= ST_SETUP;
                Psel    <= onehot(idx_s);
              end
            end
          end else begin
            state_r   <= ST_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= RESP_OKAY;
          end
        end
        ST_WLATCH: begin
          // Hwdata is only valid in the AHB data phase, one cycle after capture
          Pwdata  <= Hwdata;
          Psel    <= onehot(idx_r);
          state_r <= ST_SETUP;
        end
        ST_SETUP: begin
          Penable <= 1'b1;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (Pready) begin
            Psel       <= '0;
            Penable    <= 1'b0;
            tout_cnt_r <= '0;
            if (Pslverr) begin
              state_r <= ST_ERR1;
              Hresp   <= RESP_ERROR;
            end else begin
              state_r   <= ST_IDLE;
              Hreadyout <= 1'b1;
              if (!Pwrite) begin
                Hrdata <= Prdata;
              end
            end
          end else if ((TIMEOUT_CYC != 0) && (tout_cnt_r == CNT_W'(TIMEOUT_CYC - 1))) begin
            Psel       <= '0;
            Penable    <= 1'b0;
            tout_cnt_r <= '0;
            state_r    <= ST_ERR1;
            Hresp      <= RESP_ERROR;
          end else begin
            tout_cnt_r <= tout_cnt_r + CNT_W'(1);
          end
        end
        ST_ERR1: begin
          Hreadyout <= 1'b1;
          state_r   <= ST_ERR2;
        end
        default: begin
          state_r    <= ST_IDLE;
          tout_cnt_r <= '0;
          Hreadyout  <= 1'b1;
          Hresp      <= RESP_OKAY;
          Psel       <= '0;
          Penable    <= 1'b0;
        end
      endcase
    end
  end

endmodule
